sram_controller: RTL and testbench

- Sequences the board's external 256K x 16 asynchronous SRAM on behalf of the 2-way cache controller.
- Serves 64-bit line fills (four 16-bit beats) for cache read misses.
- Serves 32-bit write-through stores (two 16-bit beats).
- Signals completion with a one-cycle ready pulse.
- Sits between the cache controller's SRAM-side interface and the SRAM pins; it is the only master on the SRAM.

---
 rtl/sram_controller_if.sv | 12 +
 rtl/sram_controller.sv | 136 +++++++++++++
 tb/tb_sram_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// Cache-side request/response bundle for the SRAM sequencer.
interface sram_controller_if;
    logic        rdEn;
    logic        wrEn;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [63:0] readData;
    logic        ready;

    modport master (output rdEn, wrEn, address, writeData, input readData, ready);
    modport slave  (input rdEn, wrEn, address, writeData, output readData, ready);
endinterface

// File: rtl/sram_controller.sv
// Sequences a 256K x 16 asynchronous SRAM: 4-beat line fills and 2-beat
// write-through stores, each beat ACCESS_CYCLES clocks, with a one-cycle
// ready pulse on completion.
module sram_controller #(
    parameter int ADDR_BASE     = 1024,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    output logic [17:0]        sramAddr,
    inout  wire  [15:0]        sramDq,
    output logic               sramCeN,
    output logic               sramOeN,
    output logic               sramWeN,
    output logic               sramUbN,
    output logic               sramLbN
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [3:0] LAST_CYC = 4'(ACCESS_CYCLES - 1);

    state_t      state, nstate;
    logic [3:0]  cycCnt;
    logic [1:0]  beatCnt;
    logic [31:0] eff;
    logic [18:2] effQ;
    logic [31:0] wdQ;
    logic [63:0] rdata;
    logic        beatLast;
    logic        driveDq;
    logic        readyC;

    // Only eff[18:2] matters; upper bits wrap the 512 KB window away.
    assign eff = bus.address - 32'(ADDR_BASE);
    wire unused_eff = &{1'b0, eff[31:19], eff[1:0]};

    assign beatLast     = (cycCnt == LAST_CYC);
    assign bus.readData = rdata;
    assign bus.ready    = readyC;
    assign sramDq       = driveDq ? (beatCnt[0] ? wdQ[31:16] : wdQ[15:0]) : 16'hzzzz;

    // State register; reset drops straight to IDLE so strobes release at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next state and SRAM strobes; write wins when both requests are up.
    always_comb begin
        nstate  = state;
        sramCeN = 1'b1;
        sramOeN = 1'b1;
        sramWeN = 1'b1;
        sramUbN = 1'b1;
        sramLbN = 1'b1;
        driveDq = 1'b0;
        readyC  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wrEn)      nstate = WRITE;
                else if (bus.rdEn) nstate = READ;
            end
            READ: begin
                sramCeN = 1'b0;
                sramOeN = 1'b0;
                sramUbN = 1'b0;
                sramLbN = 1'b0;
                if (beatLast && beatCnt == 2'd3) nstate = DONE;
            end
            WRITE: begin
                sramCeN = 1'b0;
                sramUbN = 1'b0;
                sramLbN = 1'b0;
                // WE rises on the final cycle so address/data straddle the edge.
                sramWeN = beatLast;
                driveDq = 1'b1;
                if (beatLast && beatCnt == 2'd1) nstate = DONE;
            end
            DONE: begin
                readyC = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    // Cycle-within-beat and beat counters, cleared outside active beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycCnt  <= '0;
            beatCnt <= '0;
        end else if (state == READ || state == WRITE) begin
            if (beatLast) begin
                cycCnt  <= '0;
                beatCnt <= beatCnt + 2'd1;
            end else begin
                cycCnt <= cycCnt + 4'd1;
            end
        end else begin
            cycCnt  <= '0;
            beatCnt <= '0;
        end
    end

    // Request latch and SRAM address; address advances at each beat boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            effQ     <= '0;
            wdQ      <= '0;
            sramAddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.wrEn) begin
                        effQ     <= eff[18:2];
                        wdQ      <= bus.writeData;
                        sramAddr <= {eff[18:2], 1'b0};
                    end else if (bus.rdEn) begin
                        effQ     <= eff[18:2];
                        sramAddr <= {eff[18:3], 2'b00};
                    end
                end
                READ:  if (beatLast && beatCnt != 2'd3) sramAddr <= {effQ[18:3], beatCnt + 2'd1};
                WRITE: if (beatLast && beatCnt == 2'd0) sramAddr <= {effQ[18:2], 1'b1};
                default: ;
            endcase
        end
    end

    // Capture each read beat on its last cycle; held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         rdata <= '0;
        else if (state == READ && beatLast) rdata[{beatCnt, 4'b0000} +: 16] <= sramDq;
    end
endmodule

// File: tb/tb_sram_controller.sv
// Directed bench: two controllers (ACCESS_CYCLES 2 and 4), each on its own
// behavioural SRAM; table of transactions plus hand-written corner sequences.
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rd = 1'b0, wr = 1'b0, sel4 = 1'b0;
    logic [31:0] addr = '0, wdata = '0;

    sram_controller_if b2();
    sram_controller_if b4();
    assign b2.rdEn = rd & ~sel4;
    assign b2.wrEn = wr & ~sel4;
    assign b4.rdEn = rd & sel4;
    assign b4.wrEn = wr & sel4;
    assign b2.address = addr;
    assign b4.address = addr;
    assign b2.writeData = wdata;
    assign b4.writeData = wdata;

    wire  [15:0] dq2, dq4;
    logic [17:0] a2, a4;
    logic ce2, oe2, we2, ub2, lb2, ce4, oe4, we4, ub4, lb4;
    pullup (dq2);
    pullup (dq4);

    sram_controller #(.ADDR_BASE(1024), .ACCESS_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(b2), .sramAddr(a2), .sramDq(dq2),
        .sramCeN(ce2), .sramOeN(oe2), .sramWeN(we2), .sramUbN(ub2), .sramLbN(lb2));
    sram_controller #(.ADDR_BASE(1024), .ACCESS_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(b4), .sramAddr(a4), .sramDq(dq4),
        .sramCeN(ce4), .sramOeN(oe4), .sramWeN(we4), .sramUbN(ub4), .sramLbN(lb4));

    logic [15:0] mem2 [0:262143];
    logic [15:0] mem4 [0:262143];
    assign dq2 = (!ce2 && !oe2 && we2) ? mem2[a2] : 16'hzzzz;
    assign dq4 = (!ce4 && !oe4 && we4) ? mem4[a4] : 16'hzzzz;

    // SRAM models: preload, then latch data on WE rising edge.
    initial begin
        for (int i = 0; i < 262144; i++) mem2[i] = 16'h0000;
        mem2[4] = 16'h1111; mem2[5] = 16'h2222; mem2[6] = 16'h3333; mem2[7] = 16'h4444;
        forever begin
            @(posedge we2);
            if (!ce2) mem2[a2] = dq2;
        end
    end
    initial begin
        for (int i = 0; i < 262144; i++) mem4[i] = 16'h0000;
        forever begin
            @(posedge we4);
            if (!ce4) mem4[a4] = dq4;
        end
    end

    wire        ceS  = sel4 ? ce4 : ce2;
    wire        oeS  = sel4 ? oe4 : oe2;
    wire        weS  = sel4 ? we4 : we2;
    wire        ubS  = sel4 ? ub4 : ub2;
    wire        lbS  = sel4 ? lb4 : lb2;
    wire        rdyS = sel4 ? b4.ready : b2.ready;
    wire [63:0] rdS  = sel4 ? b4.readData : b2.readData;
    wire [17:0] aS   = sel4 ? a4 : a2;
    wire [15:0] dqS  = sel4 ? dq4 : dq2;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One transaction on the selected controller, monitored cycle by cycle.
    task automatic do_txn(input bit w, input bit r, input logic [31:0] ad, input logic [31:0] wd,
                          input logic [63:0] exp_rd, input logic [17:0] a0, input int ac,
                          input string tag);
        int nb, lat, nrdy, weLow, oeLow, nadr;
        logic [17:0] prev;
        bit badAddr, badDq, badBe;
        nb = w ? 2 : 4;
        lat = -1; nrdy = 0; weLow = 0; oeLow = 0; nadr = 0; prev = '0;
        badAddr = 0; badDq = 0; badBe = 0;
        @(negedge clk);
        wr = w; rd = r; addr = ad; wdata = wd;
        for (int c = 0; c < 4 * ac + 8; c++) begin
            @(posedge clk); #1;
            if (!weS) weLow++;
            if (!oeS) oeLow++;
            if (!ceS) begin
                if (ubS || lbS) badBe = 1;
                if (nadr == 0 || aS != prev) begin
                    if (aS !== a0 + 18'(nadr)) badAddr = 1;
                    nadr++;
                    prev = aS;
                end
            end else if (dqS !== 16'hFFFF) badDq = 1;
            if (rdyS) begin
                nrdy++;
                if (lat < 0) lat = c + 1;
                wr = 0; rd = 0;
            end
        end
        chk({tag, "_latency"},  64'(lat),   64'(nb * ac + 1));
        chk({tag, "_readycnt"}, 64'(nrdy),  64'd1);
        chk({tag, "_nbeats"},   64'(nadr),  64'(nb));
        chk({tag, "_addrseq"},  64'(badAddr), 64'd0);
        chk({tag, "_byteen"},   64'(badBe), 64'd0);
        chk({tag, "_weLow"},    64'(weLow), w ? 64'(nb * (ac - 1)) : 64'd0);
        chk({tag, "_oeLow"},    64'(oeLow), w ? 64'd0 : 64'(4 * ac));
        chk({tag, "_dqIdle"},   64'(badDq), 64'd0);
        chk({tag, "_readData"}, rdS, exp_rd);
    endtask

    typedef struct {
        bit          w;
        bit          r;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [63:0] exp;
        logic [17:0] a0;
    } vec_t;
    vec_t vt [5];

    initial begin
        int r1, r2, n;
        bit bad;

        vt[0] = '{0, 1, 32'd1036, 32'h0,        64'h4444_3333_2222_1111, 18'h00004};
        vt[1] = '{1, 0, 32'd1032, 32'hDEADBEEF, 64'h4444_3333_2222_1111, 18'h00004};
        vt[2] = '{0, 1, 32'd1039, 32'h0,        64'h4444_3333_DEAD_BEEF, 18'h00004};
        vt[3] = '{1, 0, 32'd0,    32'h12345678, 64'h4444_3333_DEAD_BEEF, 18'h3FE00};
        vt[4] = '{0, 1, 32'd0,    32'h0,        64'h0000_0000_1234_5678, 18'h3FE00};

        // Reset, then ten idle cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {59'd0, ce2, oe2, we2, ub2, lb2}, 64'h1F);
        chk("rst_readData", b2.readData, 64'd0);
        chk("rst_sramAddr", 64'(a2), 64'd0);
        chk("rst_dq", 64'(dq2), 64'hFFFF);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (b2.ready || !ce2 || !oe2 || !we2 || dq2 !== 16'hFFFF || b2.readData !== 64'd0) bad = 1;
        end
        chk("idle_quiet", 64'(bad), 64'd0);

        for (int i = 0; i < 5; i++) do_txn(vt[i].w, vt[i].r, vt[i].ad, vt[i].wd, vt[i].exp, vt[i].a0, 2, $sformatf("vec%0d", i));

        // Both requests: write first, then the held read from IDLE.
        @(negedge clk);
        wr = 1; rd = 1; addr = 32'd1024; wdata = 32'hCAFEF00D;
        r1 = -1; r2 = -1; n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (b2.ready) begin
                n++;
                if (n == 1) begin r1 = c + 1; wr = 0; end
                else begin r2 = c + 1; rd = 0; end
            end
        end
        rd = 0; wr = 0;
        chk("both_write_ready", 64'(r1), 64'd5);
        chk("both_read_ready",  64'(r2), 64'd15);
        chk("both_pulses",      64'(n),  64'd2);
        chk("both_readData",    b2.readData, 64'h0000_0000_CAFE_F00D);

        // Reset during read beat 2.
        @(negedge clk);
        rd = 1; addr = 32'd1036;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_strobes", {61'd0, ce2, oe2, we2}, 64'h7);
        chk("abort_readData", b2.readData, 64'd0);
        chk("abort_dq", 64'(dq2), 64'hFFFF);
        rd = 0;
        bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (b2.ready) bad = 1;
        end
        chk("abort_noready", 64'(bad), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_txn(0, 1, 32'd1036, 32'h0, 64'h4444_3333_DEAD_BEEF, 18'h00004, 2, "after_abort");

        // Four-cycle beats with wrap to the top of the SRAM.
        sel4 = 1'b1;
        do_txn(1, 0, 32'd1024 + 32'h7FFF8, 32'hA5A55A5A, 64'd0,                  18'h3FFFC, 4, "ac4_write");
        do_txn(0, 1, 32'd1024 + 32'h7FFF8, 32'h0,        64'h0000_0000_A5A5_5A5A, 18'h3FFFC, 4, "ac4_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
